// File: rtl/spi_pkt_pkg.sv
// spi_pkt_pkg: shared FSM state type and width helpers for the SPI packet serializer.
package spi_pkt_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  function automatic int bcnt_w(input int pkt_w);
    return $clog2(pkt_w + 1);
  endfunction
endpackage

// File: rtl/spi_pkt_serializer_if.sv
// spi_pkt_serializer_if: packet-in / SPI-out bundle; SPI_RX_EN adds miso and rx_data.
interface spi_pkt_serializer_if #(parameter int PKT_W = 64);
  logic pkt_rec;
  logic [PKT_W-1:0] shift_buf;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic [PKT_W-1:0] SPI_out;
  logic pkt_done;
  logic busy;
  logic full;
  logic overflow;
`ifdef SPI_RX_EN
  logic miso;
  logic [PKT_W-1:0] rx_data;
  modport slave (input pkt_rec, shift_buf, miso,
                 output sclk, cs_n, mosi, SPI_out, pkt_done, busy, full, overflow, rx_data);
  modport master (output pkt_rec, shift_buf, miso,
                  input sclk, cs_n, mosi, SPI_out, pkt_done, busy, full, overflow, rx_data);
`else
  modport slave (input pkt_rec, shift_buf,
                 output sclk, cs_n, mosi, SPI_out, pkt_done, busy, full, overflow);
  modport master (output pkt_rec, shift_buf,
                  input sclk, cs_n, mosi, SPI_out, pkt_done, busy, full, overflow);
`endif
endinterface

// File: rtl/spi_pkt_fifo.sv
// spi_pkt_fifo: DEPTH x PKT_W synchronous FIFO; a push while full is taken if a pop lands in the same cycle.
module spi_pkt_fifo #(
  parameter int PKT_W = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PKT_W-1:0] din,
  output logic [PKT_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic wr_en;
  assign wr_en = push & (~full | pop);
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wr_en) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/spi_pkt_serializer.sv
// spi_pkt_serializer: queues packets on pkt_rec rising edges and sends them MSB-first as an SPI mode-0 master.
// Optional SPI_RX_EN adds miso capture into rx_data. rst is asynchronous, active low.
module spi_pkt_serializer
  import spi_pkt_pkg::*;
#(
  parameter int PKT_W   = 64,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 4
) (
  input logic clk_SPI,
  input logic rst,
  spi_pkt_serializer_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = bcnt_w(PKT_W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [PKT_W-1:0] sh, dout, spi_out_q;
  logic pkt_rec_q, push, pop, tick, rise, full, empty;
  logic sclk_q, cs_n_q, mosi_q, done_q, ovf_q;
  assign push = bus.pkt_rec & ~pkt_rec_q;
  assign pop = (state == IDLE) & ~empty;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign rise = tick & ((state == SETUP) | ((state == SHIFT) & ~sclk_q));
  assign bus.sclk = sclk_q;
  assign bus.cs_n = cs_n_q;
  assign bus.mosi = mosi_q;
  assign bus.SPI_out = spi_out_q;
  assign bus.pkt_done = done_q;
  assign bus.overflow = ovf_q;
  assign bus.full = full;
  assign bus.busy = (state != IDLE) | ~empty;
  spi_pkt_fifo #(.PKT_W(PKT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_SPI), .rst(rst), .push(push), .pop(pop),
    .din(bus.shift_buf), .dout(dout), .full(full), .empty(empty)
  );
`ifdef SPI_RX_EN
  logic [PKT_W-1:0] rx_sh, rx_q;
  assign bus.rx_data = rx_q;
`endif
  always_ff @(posedge clk_SPI or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      pkt_rec_q <= 1'b1;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
      spi_out_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef SPI_RX_EN
      rx_sh <= '0;
      rx_q <= '0;
`endif
    end else begin
      pkt_rec_q <= bus.pkt_rec;
      done_q <= 1'b0;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (push & full & ~pop) ovf_q <= 1'b1;
      if (rise) bcnt <= bcnt + 1'b1;
`ifdef SPI_RX_EN
      if (rise) rx_sh <= {rx_sh[PKT_W-2:0], bus.miso};
`endif
      case (state)
        IDLE: if (pop) begin
          sh <= dout;
          mosi_q <= dout[PKT_W-1];
          cs_n_q <= 1'b0;
          cnt <= '0;
          bcnt <= '0;
          state <= SETUP;
        end
        SETUP: if (tick) begin
          sclk_q <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (tick) begin
          sclk_q <= ~sclk_q;
          // rotating keeps the original packet in sh after PKT_W falls
          if (sclk_q) begin
            sh <= {sh[PKT_W-2:0], sh[PKT_W-1]};
            if (bcnt == BW'(PKT_W)) begin
              state <= GAP;
              cs_n_q <= 1'b1;
              spi_out_q <= {sh[PKT_W-2:0], sh[PKT_W-1]};
              done_q <= 1'b1;
`ifdef SPI_RX_EN
              rx_q <= rx_sh;
`endif
            end else mosi_q <= sh[PKT_W-2];
          end
        end
        GAP: if (tick) state <= IDLE;
      endcase
    end
endmodule

// File: doc/spi_pkt_serializer.md
Name: spi_pkt_serializer

Overview:
Single-clock successor to the packet sync stage. Captures PKT_W-bit packets on each pkt_rec rising edge into a DEPTH-entry FIFO, then serialises each packet MSB-first on an SPI mode-0 master interface (sclk/cs_n/mosi).
SPI_out holds the last fully transmitted packet. Sits between the packet receiver (pkt_rec/shift_buf already in clk_SPI domain) and the off-chip SPI pins.

Parameters:
PKT_W, 64, packet width in bits (>=2)
DEPTH, 4, FIFO entries (power of 2, >=2)
CLK_DIV, 4, clk_SPI cycles per sclk half-period (>=2)

Ports:
clk_SPI  in  1  sole clock
rst  in  1  asynchronous, active-low reset
pkt_rec  in  1  packet-valid level; a push occurs on its rising edge
shift_buf  in  PKT_W  packet data, sampled in the rising-edge cycle
sclk  out  1  SPI clock, idle low
cs_n  out  1  chip select, active low
mosi  out  1  serial data, MSB first
SPI_out  out  PKT_W  last completed packet
pkt_done  out  1  one-cycle pulse when a frame completes
busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
full  out  1  FIFO full
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (async assert, sync release): cs_n=1, sclk=0, mosi=0, SPI_out=0, pkt_done=0, busy=0, full=0, overflow=0, FIFO emptied, FSM=IDLE, pkt_rec_q=1 so a pkt_rec already high at release does not push.
- Push = pkt_rec & ~pkt_rec_q; exactly one push per high level regardless of pulse length.
- Push while full: dropped, overflow set until reset. Exception: full plus a same-cycle pop accepts the push.
- tick: one-cycle strobe every CLK_DIV cycles. The divider counter clears on entry to SETUP.
- IDLE: if FIFO non-empty, pop into the shifter, drive mosi=MSB, set cs_n=0 and go to SETUP in the same clock edge.
- SETUP: on tick, set sclk=1 and go to SHIFT. This gives one half-period of cs_n-to-first-edge setup.
- SHIFT: each tick toggles sclk.
  - On a falling transition (1->0), shift the shifter left and drive mosi with the next bit.
  - Bit counter counts rising edges. After the PKT_W-th falling edge, go to GAP.
- GAP: cs_n=1 and sclk=0 for one half-period. On entry, SPI_out <= transmitted packet and pkt_done pulses for 1 cycle. On tick, go to IDLE.
- Frame timing: cs_n low for exactly (2*PKT_W)*CLK_DIV cycles. Back-to-back frames are separated by CLK_DIV+1 cycles of cs_n high.
- mosi is held during GAP and IDLE at the last bit value. It is 0 only after reset.
- A pkt_rec push during an active frame is queued and never disturbs the frame in flight.
- Reset mid-frame aborts immediately to the reset values; no partial SPI_out update.

Optional Feature:
SPI_RX_EN
- Defined: adds input miso(1) and output rx_data(PKT_W). miso is sampled on every sclk rising transition into an rx shifter, MSB first; rx_data is updated with pkt_done. rx_data reset=0.
- Undefined: no miso/rx_data ports and no rx logic; all other behaviour is identical.

Decomposition:
- Package spi_pkt_pkg: FSM state enum (IDLE, SETUP, SHIFT, GAP), the state width, and a localparam helper for the bit-counter width, $clog2(PKT_W+1).
- Sub-module spi_pkt_fifo:
  - synchronous FIFO of DEPTH x PKT_W;
  - push/pop/full/empty;
  - accepts push-on-full when pop is in the same cycle;
  - pointer width $clog2(DEPTH)+1 for full/empty discrimination.

Test Plan (PKT_W=8, CLK_DIV=2, DEPTH=4):
1. Single packet: shift_buf=8'hA5, pkt_rec high 10 cycles.
   - Exactly one frame; mosi bits sampled on sclk rise = 1,0,1,0,0,1,0,1.
   - cs_n low 32 cycles; SPI_out=8'hA5 with a 1-cycle pkt_done.
2. Queueing: five pushes 8'h01..8'h05 in quick succession during frame 1.
   - Frames 01,02,03,04 transmitted in order, since the FIFO absorbs 4 while 01 is in flight.
   - 05 accepted only if the FIFO had space. Check overflow against a FIFO-occupancy model; overflow stays 1 after the next pushes.
3. Overflow: hold frames by filling the FIFO (4 entries) plus one active frame, then push 8'hFF.
   - overflow=1, 8'hFF never appears on mosi; full deasserts after the next pop.
4. Reset mid-frame: assert rst at sclk edge 3 of 8'h3C.
   - Same cycle: cs_n=1, sclk=0, SPI_out=0, busy=0. After release, no frame is sent without a new push.
5. Reset release with pkt_rec already high: no push, busy stays 0. The next 0->1 edge produces exactly one frame.
6. SPI_RX_EN defined: miso loops back mosi, send 8'h96 -> rx_data=8'h96 at pkt_done.
